// File: rtl/rename_regfile.sv
`default_nettype none
// ============================================================================
// Module   : rename_regfile
// Brief    : Architectural register file with per-register rename tags.
//            It has NREAD combinational read ports and one issue port that
//            renames a register. Its one commit port writes a value, and
//            clears the tag only when the tag still names the retiring ROB
//            entry. Flush clears every tag, x0 is hardwired to zero, and
//            the module keeps a registered count of busy registers.
// Options  : RENAME_RF_BYPASS_EN -- forwards a same-cycle commit to the
//            read ports.
// Revision : 1.0 - initial release
// ============================================================================
module rename_regfile #(
    parameter  int XLEN  = 32,
    parameter  int NREG  = 32,
    parameter  int ROB_W = 4,
    parameter  int NREAD = 2,
    localparam int RW    = $clog2(NREG),
    localparam int TW    = ROB_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic [NREAD*RW-1:0]   rs,
    output logic [NREAD*XLEN-1:0] val,
    output logic [NREAD*TW-1:0]   tag,
    input  logic                  issue,
    input  logic [RW-1:0]         issue_rd,
    input  logic [ROB_W-1:0]      issue_rob_pos,
    input  logic                  commit,
    input  logic [RW-1:0]         commit_rd,
    input  logic [ROB_W-1:0]      commit_rob_pos,
    input  logic [XLEN-1:0]       commit_val,
    input  logic                  flush,
    output logic [RW:0]           busy_cnt
);

    // Register values and rename tags ({busy, rob_pos}). Entry 0 is never
    // written, so x0 stays zero from reset on.
    logic [XLEN-1:0] v     [NREG];
    logic [TW-1:0]   t     [NREG];
    logic [TW-1:0]   t_nxt [NREG];
    logic [RW:0]     cnt_nxt;

    logic commit_en;
    logic commit_match;
    logic issue_en;

    assign commit_en    = rdy && commit && (commit_rd != '0);
    assign commit_match = (t[commit_rd] == {1'b1, commit_rob_pos});
    assign issue_en     = rdy && issue && (issue_rd != '0) && !flush;

    // Next tag state: commit first, then issue overrides; flush clears all.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            t_nxt[r] = t[r];
        end
        if (commit_en && commit_match) begin
            t_nxt[commit_rd] = '0;
        end
        if (rdy && flush) begin
            for (int r = 0; r < NREG; r++) begin
                t_nxt[r] = '0;
            end
        end else if (issue_en) begin
            t_nxt[issue_rd] = {1'b1, issue_rob_pos};
        end
    end

    // Busy count taken from the post-update tags so that busy_cnt is current.
    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt = cnt_nxt + {{RW{1'b0}}, t_nxt[r][ROB_W]};
        end
    end

    // State update; rdy low holds everything because t_nxt equals t.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                v[r] <= '0;
                t[r] <= '0;
            end
            busy_cnt <= '0;
        end else if (rdy) begin
            for (int r = 0; r < NREG; r++) begin
                t[r] <= t_nxt[r];
            end
            if (commit_en) begin
                v[commit_rd] <= commit_val;
            end
            busy_cnt <= cnt_nxt;
        end
    end

    generate
        for (genvar k = 0; k < NREAD; k++) begin : g_read
            logic [RW-1:0]   idx;
            logic [XLEN-1:0] rd_val;
            logic [TW-1:0]   rd_tag;

            assign idx = rs[k*RW +: RW];

            // Combinational read of stored state, optionally bypassing commit.
            always_comb begin
                rd_val = v[idx];
                rd_tag = t[idx];
`ifdef RENAME_RF_BYPASS_EN
                if (commit_en && (idx == commit_rd)) begin
                    rd_val = commit_val;
                    if (commit_match) begin
                        rd_tag = '0;
                    end
                end
`endif
                if (idx == '0) begin
                    rd_val = '0;
                    rd_tag = '0;
                end
            end

            assign val[k*XLEN +: XLEN] = rd_val;
            assign tag[k*TW +: TW]     = rd_tag;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rename_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_rename_regfile
// Brief    : Scoreboard bench for rename_regfile. The driver pushes the
//            expected read values, read tags and busy counts. A monitor
//            pops and compares them on each falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rename_regfile;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int ROB_W = 4;
    localparam int NREAD = 2;
    localparam int RW    = 5;
    localparam int TW    = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  rdy;
    logic [NREAD*RW-1:0]   rs;
    logic [NREAD*XLEN-1:0] val;
    logic [NREAD*TW-1:0]   tag;
    logic                  issue;
    logic [RW-1:0]         issue_rd;
    logic [ROB_W-1:0]      issue_rob_pos;
    logic                  commit;
    logic [RW-1:0]         commit_rd;
    logic [ROB_W-1:0]      commit_rob_pos;
    logic [XLEN-1:0]       commit_val;
    logic                  flush;
    logic [RW:0]           busy_cnt;

    rename_regfile #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .ROB_W (ROB_W),
        .NREAD (NREAD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .rs             (rs),
        .val            (val),
        .tag            (tag),
        .issue          (issue),
        .issue_rd       (issue_rd),
        .issue_rob_pos  (issue_rob_pos),
        .commit         (commit),
        .commit_rd      (commit_rd),
        .commit_rob_pos (commit_rob_pos),
        .commit_val     (commit_val),
        .flush          (flush),
        .busy_cnt       (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int          kind;   // 0 = val, 1 = tag, 2 = busy_cnt
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: compare every queued expectation against live outputs.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = q.pop_front();
                case (e.kind)
                    0:       act = val[e.port*XLEN +: XLEN];
                    1:       act = {27'd0, tag[e.port*TW +: TW]};
                    default: act = {26'd0, busy_cnt};
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", e.nm, act, e.exp);
                end
            end
        end
    end

    task automatic rd(input int port, input int idx, input logic [31:0] ev,
                      input logic [31:0] et, input string nm);
        exp_t e;
        rs[port*RW +: RW] = idx[RW-1:0];
        e.nm = {nm, "_val"}; e.kind = 0; e.port = port; e.exp = ev;
        q.push_back(e);
        e.nm = {nm, "_tag"}; e.kind = 1; e.port = port; e.exp = et;
        q.push_back(e);
    endtask

    task automatic exp_busy(input int n, input string nm);
        exp_t e;
        e.nm = nm; e.kind = 2; e.port = 0; e.exp = n;
        q.push_back(e);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        issue  = 1'b0;
        commit = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic do_issue(input int rd_i, input int pos);
        issue         = 1'b1;
        issue_rd      = rd_i[RW-1:0];
        issue_rob_pos = pos[ROB_W-1:0];
    endtask

    task automatic do_commit(input int rd_i, input int pos, input logic [31:0] cv);
        commit         = 1'b1;
        commit_rd      = rd_i[RW-1:0];
        commit_rob_pos = pos[ROB_W-1:0];
        commit_val     = cv;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rdy = 1'b1; rs = '0;
        issue = 1'b0; issue_rd = '0; issue_rob_pos = '0;
        commit = 1'b0; commit_rd = '0; commit_rob_pos = '0; commit_val = '0;
        flush = 1'b0;

        // Reset state
        sample();
        rd(0, 5, 0, 0, "rst_p0_x5"); rd(1, 0, 0, 0, "rst_p1_x0"); exp_busy(0, "rst_busy");
        sample();
        rd(0, 0, 0, 0, "rst_p0_x0"); rd(1, 5, 0, 0, "rst_p1_x5");
        sample();
        rst_n = 1'b1;

        // Issue then matching commit
        do_issue(3, 2); tick();
        rd(0, 3, 0, 32'h12, "iss_x3"); exp_busy(1, "iss_busy");
        sample();
        do_commit(3, 2, 32'hDEADBEEF); tick();
        rd(1, 3, 32'hDEADBEEF, 0, "cmt_x3"); exp_busy(0, "cmt_busy");
        sample();

        // Older commit must not clear a younger rename
        do_issue(3, 2); tick();
        do_issue(3, 6); tick();
        exp_busy(1, "reissue_busy");
        sample();
        do_commit(3, 2, 32'h11); tick();
        rd(0, 3, 32'h11, 32'h16, "old_cmt_x3"); exp_busy(1, "old_cmt_busy");
        sample();
        do_commit(3, 6, 32'h22); tick();
        rd(0, 3, 32'h22, 0, "young_cmt_x3"); exp_busy(0, "young_cmt_busy");
        sample();

        // Same-cycle matching commit and issue on one register
        do_issue(4, 1); tick();
        do_commit(4, 1, 32'hCAFE); do_issue(4, 7); tick();
        rd(1, 4, 32'hCAFE, 32'h17, "cmt_iss_x4"); exp_busy(1, "cmt_iss_busy");
        sample();

        // Flush with same-cycle commit and issue
        do_issue(1, 3); tick();
        do_issue(2, 4); tick();
        do_issue(7, 5); tick();
        rd(0, 2, 0, 32'h14, "pre_flush_x2"); exp_busy(4, "pre_flush_busy");
        sample();
        flush = 1'b1; do_commit(2, 4, 32'h55); do_issue(9, 8); tick();
        rd(0, 2, 32'h55, 0, "flush_x2"); rd(1, 1, 0, 0, "flush_x1"); exp_busy(0, "flush_busy");
        sample();
        rd(0, 9, 0, 0, "flush_x9"); rd(1, 7, 0, 0, "flush_x7");
        sample();

        // rdy low holds all state
        rdy = 1'b0; do_issue(5, 1); do_commit(3, 0, 32'h99); tick();
        rdy = 1'b1;
        rd(0, 5, 0, 0, "hold_x5"); rd(1, 3, 32'h22, 0, "hold_x3"); exp_busy(0, "hold_busy");
        sample();

        // x0 is hardwired
        do_issue(0, 1); do_commit(0, 1, 32'h77); tick();
        rd(0, 0, 0, 0, "x0_write"); exp_busy(0, "x0_busy");
        sample();

        // Same-cycle read of a register being committed (matching tag)
        do_issue(3, 2); tick();
        do_commit(3, 2, 32'hA5);
`ifdef RENAME_RF_BYPASS_EN
        rd(1, 3, 32'hA5, 0, "byp_match_x3");
`else
        rd(1, 3, 32'h22, 32'h12, "byp_match_x3");
`endif
        sample();
        tick();
        rd(1, 3, 32'hA5, 0, "after_cmt_x3"); exp_busy(0, "after_cmt_busy");
        sample();

        // Same-cycle read of a register being committed (stale tag)
        do_issue(6, 9); tick();
        do_commit(6, 3, 32'h66);
`ifdef RENAME_RF_BYPASS_EN
        rd(0, 6, 32'h66, 32'h19, "byp_stale_x6");
`else
        rd(0, 6, 0, 32'h19, "byp_stale_x6");
`endif
        sample();
        tick();
        rd(0, 6, 32'h66, 32'h19, "stale_cmt_x6"); exp_busy(1, "stale_busy");
        sample();

        // Asynchronous reset mid-operation
        #2 rst_n = 1'b0;
        #1;
        rd(0, 6, 0, 0, "areset_x6"); rd(1, 3, 0, 0, "areset_x3"); exp_busy(0, "areset_busy");
        sample();
        rst_n = 1'b1;

        sample();
        sample();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
